uart_frame_check: RTL and testbench

Parametrised frame-integrity checker for the UART receive path, successor to the single-bit stop checker. Sits beside the Rx FSM and sampler: it consumes the same sampled bit under per-field strobes and checks parity (even/odd) plus a configurable number of stop bits. It reports per-frame errors with a registered frame-done/frame-OK pulse and keeps a saturating count of errored frames.

---
 rtl/uart_frame_check_if.sv | 41 ++++
 rtl/uart_frame_check.sv | 147 ++++++++++++++
 tb/tb_uart_frame_check.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_check_if.sv
// uart_frame_check_if: groups the frame-check strobes, sampled data and
// the check results between the UART Rx path and uart_frame_check.
//   master : Rx FSM / sampler side, drives strobes and data, reads results
//   slave  : frame checker side
// brk_det exists only when UART_FRAME_CHK_BREAK_DET_EN is defined.
interface uart_frame_check_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  frame_start;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  sampled_bit;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  par_typ;
  logic                  err_clr;
  logic                  par_err;
  logic                  stp_err;
  logic                  frame_done;
  logic                  frame_ok;
  logic [CNT_WIDTH-1:0]  err_cnt;
`ifdef UART_FRAME_CHK_BREAK_DET_EN
  logic                  brk_det;
`endif

  modport master (
    output frame_start, par_chk_en, stp_chk_en, sampled_bit, p_data, par_typ, err_clr,
`ifdef UART_FRAME_CHK_BREAK_DET_EN
    input  brk_det,
`endif
    input  par_err, stp_err, frame_done, frame_ok, err_cnt
  );

  modport slave (
    input  frame_start, par_chk_en, stp_chk_en, sampled_bit, p_data, par_typ, err_clr,
`ifdef UART_FRAME_CHK_BREAK_DET_EN
    output brk_det,
`endif
    output par_err, stp_err, frame_done, frame_ok, err_cnt
  );
endinterface

// File: rtl/uart_frame_check.sv
// uart_frame_check: frame-integrity checker for the UART receive path.
// Checks parity (even/odd) and STOP_BITS stop bits from the sampled bit
// under per-field strobes, pulses frame_done/frame_ok one cycle after the
// final stop strobe, and keeps a saturating count of errored frames.
// Ports:
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-low reset
//   fc   : uart_frame_check_if.slave (strobes, data, par_typ, err_clr in;
//          par_err, stp_err, frame_done, frame_ok, err_cnt [, brk_det] out)
// Optional feature: UART_FRAME_CHK_BREAK_DET_EN adds break detection
// (p_data == 0 and all stop samples 0) reported on brk_det; such frames
// are not counted as errors.
//
// state | meaning
// IDLE  | waiting for frame_start; stop strobes ignored
// DATA  | frame open, parity strobe accepted, no stop bit seen yet
// STOP  | at least one stop bit seen, waiting for the last one
module uart_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input logic               CLK,
  input logic               RST,
  uart_frame_check_if.slave fc
);

  localparam int SCW = (STOP_BITS > 1) ? 2 : 1;
  localparam logic [SCW-1:0] STOP_LAST = SCW'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [SCW-1:0]       stop_cnt_q, stop_cnt_d;
  logic                 par_err_q, par_err_d;
  logic                 stp_err_q, stp_err_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_ok_q, frame_ok_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 cnt_inc;
`ifdef UART_FRAME_CHK_BREAK_DET_EN
  logic                 all_zero_q, all_zero_d;
  logic                 brk_det_q, brk_det_d;
  logic                 brk_hit;
`endif

  always_comb begin
    state_d      = state_q;
    stop_cnt_d   = stop_cnt_q;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    frame_done_d = 1'b0;
    frame_ok_d   = 1'b0;
`ifdef UART_FRAME_CHK_BREAK_DET_EN
    all_zero_d   = all_zero_q;
    brk_det_d    = 1'b0;
    brk_hit      = 1'b0;
`endif
    if (fc.frame_start) begin
      // A new frame overrides any strobe arriving in the same cycle.
      state_d    = DATA;
      stop_cnt_d = '0;
      par_err_d  = 1'b0;
      stp_err_d  = 1'b0;
`ifdef UART_FRAME_CHK_BREAK_DET_EN
      all_zero_d = 1'b1;
`endif
    end else begin
      if (fc.par_chk_en && (state_q == DATA))
        par_err_d = (^fc.p_data) ^ fc.sampled_bit ^ fc.par_typ;
      if (fc.stp_chk_en && (state_q != IDLE)) begin
        stp_err_d = stp_err_q | ~fc.sampled_bit;
`ifdef UART_FRAME_CHK_BREAK_DET_EN
        all_zero_d = all_zero_q & ~fc.sampled_bit;
`endif
        if (stop_cnt_q == STOP_LAST) begin
          state_d      = IDLE;
          stop_cnt_d   = '0;
          frame_done_d = 1'b1;
`ifdef UART_FRAME_CHK_BREAK_DET_EN
          brk_hit    = all_zero_d && (fc.p_data == '0);
          brk_det_d  = brk_hit;
          frame_ok_d = ~(par_err_d | stp_err_d | brk_hit);
`else
          frame_ok_d = ~(par_err_d | stp_err_d);
`endif
        end else begin
          state_d    = STOP;
          stop_cnt_d = stop_cnt_q + SCW'(1);
        end
      end
    end
  end

  // Errored frames are counted in the frame_done cycle; break frames are not errors.
`ifdef UART_FRAME_CHK_BREAK_DET_EN
  assign cnt_inc = frame_done_q & ~frame_ok_q & ~brk_det_q;
`else
  assign cnt_inc = frame_done_q & ~frame_ok_q;
`endif

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (fc.err_clr)
      err_cnt_d = cnt_inc ? CNT_WIDTH'(1) : '0;  // keep a coincident error
    else if (cnt_inc && (err_cnt_q != {CNT_WIDTH{1'b1}}))
      err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      stop_cnt_q   <= '0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_cnt_q    <= '0;
`ifdef UART_FRAME_CHK_BREAK_DET_EN
      all_zero_q   <= 1'b0;
      brk_det_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      stop_cnt_q   <= stop_cnt_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      err_cnt_q    <= err_cnt_d;
`ifdef UART_FRAME_CHK_BREAK_DET_EN
      all_zero_q   <= all_zero_d;
      brk_det_q    <= brk_det_d;
`endif
    end
  end

  assign fc.par_err    = par_err_q;
  assign fc.stp_err    = stp_err_q;
  assign fc.frame_done = frame_done_q;
  assign fc.frame_ok   = frame_ok_q;
  assign fc.err_cnt    = err_cnt_q;
`ifdef UART_FRAME_CHK_BREAK_DET_EN
  assign fc.brk_det    = brk_det_q;
`endif

endmodule

// File: tb/tb_uart_frame_check.sv
// Bench for uart_frame_check: dut_a uses one stop bit and an 8-bit counter,
// dut_b uses two stop bits and a 2-bit counter. Both see the same stimulus;
// each test group checks only the relevant instance.
module tb_uart_frame_check;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       fs = 1'b0, pe = 1'b0, se = 1'b0, sb = 1'b0, pt = 1'b0, clr = 1'b0;
  logic [7:0] pd = 8'h00;
  int         checks = 0;
  int         failures = 0;
  int         exp_cnt;

  always #5 CLK = ~CLK;

  uart_frame_check_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) ifa ();
  uart_frame_check_if #(.DATA_WIDTH(8), .CNT_WIDTH(2)) ifb ();

  assign ifa.frame_start = fs;  assign ifb.frame_start = fs;
  assign ifa.par_chk_en  = pe;  assign ifb.par_chk_en  = pe;
  assign ifa.stp_chk_en  = se;  assign ifb.stp_chk_en  = se;
  assign ifa.sampled_bit = sb;  assign ifb.sampled_bit = sb;
  assign ifa.p_data      = pd;  assign ifb.p_data      = pd;
  assign ifa.par_typ     = pt;  assign ifb.par_typ     = pt;
  assign ifa.err_clr     = clr; assign ifb.err_clr     = clr;

  uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) dut_a (
    .CLK(CLK), .RST(RST), .fc(ifa.slave));
  uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(2)) dut_b (
    .CLK(CLK), .RST(RST), .fc(ifb.slave));

  typedef struct {
    logic [7:0] pd;
    logic       pe;
    logic       pb;
    logic       pt;
    logic       s0;
    logic       x_par;
    logic       x_stp;
    logic       x_ok;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step(input logic f, input logic p, input logic s, input logic b);
    fs = f; pe = p; se = s; sb = b;
    @(posedge CLK);
    #1;
    fs = 1'b0; pe = 1'b0; se = 1'b0; sb = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //           pd     pe    pb    pt    stop  par   stp   ok
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_par_err", {31'd0, ifa.par_err}, 0);
    chk("rst_stp_err", {31'd0, ifa.stp_err}, 0);
    chk("rst_frame_done", {31'd0, ifa.frame_done}, 0);
    chk("rst_frame_ok", {31'd0, ifa.frame_ok}, 0);
    chk("rst_err_cnt", {24'd0, ifa.err_cnt}, 0);
`ifdef UART_FRAME_CHK_BREAK_DET_EN
    chk("rst_brk_det", {31'd0, ifa.brk_det}, 0);
`endif
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // table: single-stop frames on dut_a
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      pd = vecs[i].pd;
      pt = vecs[i].pt;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (vecs[i].pe) step(1'b0, 1'b1, 1'b0, vecs[i].pb);
      step(1'b0, 1'b0, 1'b1, vecs[i].s0);
      if (!vecs[i].x_ok) exp_cnt++;
      chk($sformatf("v%0d_done", i), {31'd0, ifa.frame_done}, 1);
      chk($sformatf("v%0d_ok", i), {31'd0, ifa.frame_ok}, {31'd0, vecs[i].x_ok});
      chk($sformatf("v%0d_par", i), {31'd0, ifa.par_err}, {31'd0, vecs[i].x_par});
      chk($sformatf("v%0d_stp", i), {31'd0, ifa.stp_err}, {31'd0, vecs[i].x_stp});
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, ifa.frame_done}, 0);
      chk($sformatf("v%0d_par_hold", i), {31'd0, ifa.par_err}, {31'd0, vecs[i].x_par});
      chk($sformatf("v%0d_cnt", i), {24'd0, ifa.err_cnt}, exp_cnt);
    end

    // reset mid-frame with frame_done in flight
    do_reset();
    pd = 8'hA5; pt = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("mid_par_err_set", {31'd0, ifa.par_err}, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    RST = 1'b0;
    #2;
    chk("mid_rst_par_err", {31'd0, ifa.par_err}, 0);
    chk("mid_rst_done", {31'd0, ifa.frame_done}, 0);
    @(negedge CLK);
    RST = 1'b1;
    step(1'b0, 1'b0, 0, 1'b0);
    chk("mid_rst_cnt", {24'd0, ifa.err_cnt}, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_stop_ignored_stp", {31'd0, ifa.stp_err}, 0);
    chk("idle_stop_ignored_done", {31'd0, ifa.frame_done}, 0);

    // two stop bits on dut_b: samples 1 then 0
    do_reset();
    pd = 8'h5A;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("b_first_stop_done", {31'd0, ifb.frame_done}, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("b_done", {31'd0, ifb.frame_done}, 1);
    chk("b_stp_err", {31'd0, ifb.stp_err}, 1);
    chk("b_ok", {31'd0, ifb.frame_ok}, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_cnt1", {30'd0, ifb.err_cnt}, 1);

    // saturation on dut_b: four more errored frames -> 3
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("b_cnt_sat", {30'd0, ifb.err_cnt}, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    clr = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_clr_with_inc", {30'd0, ifb.err_cnt}, 1);

    // frame_start coincident with a zero stop strobe on dut_b
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("coinc_fs_stp_err", {31'd0, ifb.stp_err}, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("coinc_fs_cnt_zero", {31'd0, ifb.frame_done}, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("coinc_fs_done", {31'd0, ifb.frame_done}, 1);
    chk("coinc_fs_ok", {31'd0, ifb.frame_ok}, 1);

    // frame_start in the frame_done cycle on dut_a
    do_reset();
    pd = 8'hA5; pt = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("b2b_first_ok", {31'd0, ifa.frame_ok}, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b_cnt", {24'd0, ifa.err_cnt}, 1);
    chk("b2b_par_cleared", {31'd0, ifa.par_err}, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("b2b_second_ok", {31'd0, ifa.frame_ok}, 1);

    // coincident parity and final stop strobe on dut_a
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("coinc_ps_par", {31'd0, ifa.par_err}, 1);
    chk("coinc_ps_done", {31'd0, ifa.frame_done}, 1);
    chk("coinc_ps_ok", {31'd0, ifa.frame_ok}, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("coinc_ps_cnt", {24'd0, ifa.err_cnt}, 2);

    // break frame on dut_a: p_data 0, stop sample 0
    do_reset();
    pd = 8'h00;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("brk_done", {31'd0, ifa.frame_done}, 1);
    chk("brk_ok", {31'd0, ifa.frame_ok}, 0);
`ifdef UART_FRAME_CHK_BREAK_DET_EN
    chk("brk_det", {31'd0, ifa.brk_det}, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("brk_cnt", {24'd0, ifa.err_cnt}, 0);
    chk("brk_det_pulse", {31'd0, ifa.brk_det}, 0);
`else
    chk("brk_stp_err", {31'd0, ifa.stp_err}, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("brk_cnt", {24'd0, ifa.err_cnt}, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
